// File: rtl/mips_prog_loader.sv
// Boot loader for the MIPS32 core: streams a program into instruction memory,
// guarantees a trailing HLT, releases the core and reports completion.
module mips_prog_loader #(
  parameter int unsigned        ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [5:0]         HALT_OP    = 6'h3f
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_pc_clr,
  output logic              cpu_run,
  input  logic              halted_in,
  output logic              done,
  input  logic              done_ack,
  output logic [ADDR_W:0]   word_count,
  output logic              err_ovf
);

  localparam logic [31:0]     HLT_WORD = 32'hfc000000;
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE, LOAD, APPEND, RELEASE, RUN, DONE, ERROR
  } state_t;

  state_t            state, state_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [ADDR_W:0]   cnt_d;
  logic              accept;
  logic              is_hlt;
  logic [ADDR_W:0]   idx;
  logic              at_last;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= START_ADDR;
      mem_wdata  <= '0;
      word_count <= '0;
    end else begin
      state      <= state_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      word_count <= cnt_d;
    end
  end

  assign s_ready    = rst_n && ((state == IDLE) || (state == LOAD));
  assign cpu_pc_clr = (state == RELEASE);
  assign cpu_run    = (state == RUN);
  assign done       = (state == DONE);
  assign err_ovf    = (state == ERROR);

  assign accept = s_valid && s_ready;
  assign is_hlt = (s_data[31:26] == HALT_OP);
  // Index of the incoming word; word_count is stale in IDLE until the first accept.
  assign idx     = (state == IDLE) ? '0 : word_count;
  assign at_last = (idx == LAST_IDX);

  always_comb begin
    state_d = state;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    cnt_d   = word_count;
    unique case (state)
      IDLE, LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = s_data;
          addr_d  = (state == IDLE) ? START_ADDR : mem_addr + 1'b1;
          cnt_d   = idx + 1'b1;
          if (s_last) begin
            if (is_hlt)       state_d = RELEASE;
            else if (at_last) state_d = ERROR;
            else              state_d = APPEND;
          end else begin
            state_d = at_last ? ERROR : LOAD;
          end
        end
      end
      APPEND: begin
        we_d    = 1'b1;
        addr_d  = mem_addr + 1'b1;
        wdata_d = HLT_WORD;
        cnt_d   = word_count + 1'b1;
        state_d = RELEASE;
      end
      RELEASE: state_d = RUN;
      RUN:     if (halted_in) state_d = DONE;
      DONE:    if (done_ack) state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader: a 1024-word and a 4-word instance,
// each checked against a list-based model of the expected memory writes.
module tb_mips_prog_loader;

  logic        clk1;
  logic        rst_n [2];
  logic        sv    [2];
  logic [31:0] sd    [2];
  logic        sl    [2];
  logic        hin   [2];
  logic        dack  [2];
  logic        rdy   [2];
  logic        we    [2];
  logic [9:0]  ad    [2];
  logic [31:0] wd    [2];
  logic        pcclr [2];
  logic        run   [2];
  logic        dn    [2];
  logic [10:0] wc    [2];
  logic        ovf   [2];

  logic [9:0]  a0;
  logic [10:0] wc0;
  logic [1:0]  a1;
  logic [2:0]  wc1;

  assign ad[0] = a0;
  assign wc[0] = wc0;
  assign ad[1] = {8'b0, a1};
  assign wc[1] = {8'b0, wc1};

  mips_prog_loader #(.ADDR_W(10)) dut (
    .clk1(clk1), .rst_n(rst_n[0]), .s_valid(sv[0]), .s_data(sd[0]), .s_last(sl[0]),
    .s_ready(rdy[0]), .mem_we(we[0]), .mem_addr(a0), .mem_wdata(wd[0]),
    .cpu_pc_clr(pcclr[0]), .cpu_run(run[0]), .halted_in(hin[0]), .done(dn[0]),
    .done_ack(dack[0]), .word_count(wc0), .err_ovf(ovf[0])
  );

  mips_prog_loader #(.ADDR_W(2)) dut_s (
    .clk1(clk1), .rst_n(rst_n[1]), .s_valid(sv[1]), .s_data(sd[1]), .s_last(sl[1]),
    .s_ready(rdy[1]), .mem_we(we[1]), .mem_addr(a1), .mem_wdata(wd[1]),
    .cpu_pc_clr(pcclr[1]), .cpu_run(run[1]), .halted_in(hin[1]), .done(dn[1]),
    .done_ack(dack[1]), .word_count(wc1), .err_ovf(ovf[1])
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Observed writes and event counts, sampled on the falling edge.
  logic [41:0] wq0[$];
  logic [41:0] wq1[$];
  int pc_cnt [2];
  int run_cnt[2];
  int dn_cnt [2];

  initial for (int i = 0; i < 2; i++) begin pc_cnt[i] = 0; run_cnt[i] = 0; dn_cnt[i] = 0; end

  always @(negedge clk1) begin
    if (we[0]) wq0.push_back({ad[0], wd[0]});
    if (we[1]) wq1.push_back({ad[1], wd[1]});
    for (int i = 0; i < 2; i++) begin
      if (pcclr[i]) pc_cnt[i]++;
      if (run[i])   run_cnt[i]++;
      if (dn[i])    dn_cnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  task automatic send(input int i, input logic [31:0] w, input logic last, output bit acc);
    int n = 0;
    sv[i] = 1'b1; sd[i] = w; sl[i] = last;
    while (!rdy[i] && n < 8) begin tick(1); n++; end
    acc = rdy[i];
    if (acc) tick(1);
    sv[i] = 1'b0; sl[i] = 1'b0;
  endtask

  task automatic gap(input int i, input int n);
    repeat (n) begin
      sv[i] = 1'b0; sl[i] = 1'($urandom); sd[i] = $urandom;
      tick(1);
    end
  endtask

  task automatic do_reset(input int i);
    rst_n[i] = 1'b0; sv[i] = 1'b0; sl[i] = 1'b0; hin[i] = 1'b0; dack[i] = 1'b0;
    tick(1);
    check("rst_we",    we[i],    0);
    check("rst_addr",  ad[i],    0);
    check("rst_wdata", wd[i],    0);
    check("rst_pcclr", pcclr[i], 0);
    check("rst_run",   run[i],   0);
    check("rst_done",  dn[i],    0);
    check("rst_wc",    wc[i],    0);
    check("rst_ovf",   ovf[i],   0);
    check("rst_rdy",   rdy[i],   0);
    rst_n[i] = 1'b1;
    tick(1);
    check("rst_rdy_after", rdy[i], 1);
  endtask

  logic [31:0] prog_q[$];

  task automatic run_prog(input int i, input bit has_last, input int maxgap, input bit hold_halt);
    logic [41:0] expq[$];
    logic [41:0] got[$];
    int cap, n, nacc, b_w, b_pc, b_run, b_dn;
    bit err, acc;
    cap = (i == 0) ? 1024 : 4;
    n = prog_q.size();
    err = 0; nacc = 0;
    for (int k = 0; k < n; k++) begin
      bit lastk, hltk;
      expq.push_back({10'(k), prog_q[k]});
      nacc++;
      lastk = has_last && (k == n - 1);
      hltk  = (prog_q[k][31:26] == 6'h3f);
      if (k == cap - 1 && !(lastk && hltk)) begin err = 1; break; end
    end
    if (!err && has_last && prog_q[n-1][31:26] != 6'h3f)
      expq.push_back({10'(n), 32'hfc000000});

    b_w   = (i == 0) ? wq0.size() : wq1.size();
    b_pc  = pc_cnt[i]; b_run = run_cnt[i]; b_dn = dn_cnt[i];
    hin[i] = hold_halt;
    for (int k = 0; k < n; k++) begin
      gap(i, $urandom_range(maxgap, 0));
      send(i, prog_q[k], has_last && (k == n - 1), acc);
      check("accept", acc, k < nacc);
      if (!acc) break;
    end
    hin[i] = 1'b0;
    tick(4);

    got = (i == 0) ? wq0[b_w:$] : wq1[b_w:$];
    check("nwrites", got.size(), expq.size());
    for (int k = 0; k < got.size() && k < expq.size(); k++) check("write", got[k], expq[k]);
    check("ovf", ovf[i], err);
    check("done_early", dn_cnt[i] - b_dn, 0);

    if (err) begin
      check("wc_err", wc[i], expq.size());
      check("rdy_err", rdy[i], 0);
      check("run_never", run_cnt[i] - b_run, 0);
      check("pcclr_err", pc_cnt[i] - b_pc, 0);
      do_reset(i);
    end else if (!has_last) begin
      check("wc_load", wc[i], n);
      check("rdy_load", rdy[i], 1);
      check("pcclr_load", pc_cnt[i] - b_pc, 0);
      do_reset(i);
    end else begin
      check("wc", wc[i], expq.size());
      check("pcclr_once", pc_cnt[i] - b_pc, 1);
      check("run", run[i], 1);
      check("rdy_run", rdy[i], 0);
      dack[i] = 1'b1;
      tick(1);
      dack[i] = 1'b0;
      check("ack_in_run", run[i], 1);
      hin[i] = 1'b1;
      tick(1);
      hin[i] = 1'b0;
      check("run_off", run[i], 0);
      check("done", dn[i], 1);
      tick(2);
      check("done_hold", dn[i], 1);
      dack[i] = 1'b1;
      tick(1);
      dack[i] = 1'b0;
      check("done_clr", dn[i], 0);
      check("idle_rdy", rdy[i], 1);
      check("wc_kept", wc[i], expq.size());
    end
  endtask

  task automatic load_t1();
    prog_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
               32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  endtask

  task automatic load_t2();
    prog_q = '{32'h2801000a, 32'h28020014, 32'h00222000};
  endtask

  function automatic logic [31:0] rand_word(input bit hlt);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = hlt ? 6'h3f : 6'($urandom_range(62, 0));
    return w;
  endfunction

  task automatic rand_prog(input int len, input bit end_hlt);
    prog_q = {};
    for (int k = 0; k < len; k++) prog_q.push_back((k == len - 1) ? rand_word(end_hlt) : $urandom);
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; sv[i] = 1'b0; sd[i] = '0; sl[i] = 1'b0; hin[i] = 1'b0; dack[i] = 1'b0;
    end
    tick(2);
    for (int i = 0; i < 2; i++) begin
      check("init_rdy", rdy[i], 0);
      check("init_wc",  wc[i],  0);
      check("init_run", run[i], 0);
      rst_n[i] = 1'b1;
    end
    tick(1);

    load_t1(); run_prog(0, 1, 0, 0);
    load_t2(); run_prog(0, 1, 0, 0);
    load_t1(); run_prog(0, 1, 3, 1);

    // Small memory: overflow without last, exact fit with HLT, non-HLT last at the end.
    prog_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    run_prog(1, 0, 1, 0);
    prog_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hfc000000};
    run_prog(1, 1, 1, 0);
    prog_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_prog(1, 1, 1, 0);

    // Abort mid-load, then abort in RUN, then a fresh load.
    load_t1();
    for (int k = 0; k < 4; k++) send(0, prog_q[k], 1'b0, acc);
    do_reset(0);
    for (int k = 0; k < 9; k++) send(0, prog_q[k], k == 8, acc);
    tick(4);
    check("run_before_abort", run[0], 1);
    do_reset(0);
    load_t2(); run_prog(0, 1, 2, 0);

    for (int r = 0; r < 6; r++) begin
      rand_prog($urandom_range(12, 1), 1'($urandom));
      run_prog(0, 1, 3, 1'($urandom));
    end
    for (int r = 0; r < 6; r++) begin
      rand_prog($urandom_range(6, 1), 1'($urandom));
      run_prog(1, 1'($urandom), 2, 1'($urandom));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", npass, ntot);
    $fatal(1);
  end

endmodule
